// File: rtl/apb_req_arbiter_if.sv
// APB bus bundle between apb_req_arbiter (master) and its two slaves.
interface apb_req_arbiter_if;
    logic       PSEL1;
    logic       PSEL2;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;

    modport master (
        output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin APB master front-end sharing one two-slave bus between two requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT cycles.
module apb_req_arbiter
`ifdef APB_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT = 16
)
`endif
(
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [8:0] addr0,
    input  logic [8:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata,
    output logic       err,
    apb_req_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       psel1_q, psel1_d, psel2_q, psel2_d;
    logic       penable_q, penable_d, pwrite_q, pwrite_d;
    logic [7:0] paddr_q, paddr_d, pwdata_q, pwdata_d, rdata_d;
    logic       gnt0_d, gnt1_d, done0_d, done1_d, err_d;
    logic       any_req, winner, win_we, expire;
    logic [8:0] win_addr;
    logic [7:0] win_wdata;

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        any_req   = req0 | req1;
        winner    = (req0 & req1) ? ~last_q : req1;
        win_we    = winner ? we1 : we0;
        win_addr  = winner ? addr1 : addr0;
        win_wdata = winner ? wdata1 : wdata0;
    end

`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    assign expire = (state_q == ACCESS) && !bus.PREADY && (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata     <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            psel1_q   <= psel1_d;
            psel2_q   <= psel2_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata     <= rdata_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            done0     <= done0_d;
            done1     <= done1_d;
            err       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (bus.PREADY || expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of every registered output; the APB registers double as the latched command.
    always_comb begin
        owner_d   = owner_q;
        last_d    = last_q;
        psel1_d   = psel1_q;
        psel2_d   = psel2_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err_d     = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d   = winner;
                    last_d    = winner;
                    psel1_d   = ~win_addr[8];
                    psel2_d   = win_addr[8];
                    penable_d = 1'b0;
                    pwrite_d  = win_we;
                    paddr_d   = win_addr[7:0];
                    if (win_we) pwdata_d = win_wdata;
                    gnt0_d    = ~winner;
                    gnt1_d    = winner;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (bus.PREADY || expire) begin
                    psel1_d   = 1'b0;
                    psel2_d   = 1'b0;
                    penable_d = 1'b0;
                    done0_d   = ~owner_q;
                    done1_d   = owner_q;
                    if (bus.PREADY) begin
                        if (!pwrite_q) rdata_d = bus.PRDATA;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
`ifdef APB_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: ;
        endcase
    end

    assign bus.PSEL1   = psel1_q;
    assign bus.PSEL2   = psel2_q;
    assign bus.PENABLE = penable_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: vector table, hand sequences and a randomized run.
// Covers the APB_ARB_TIMEOUT_EN abort path when that macro is defined (TIMEOUT=4).
module tb_apb_req_arbiter;

    logic       PCLK;
    logic       PRESETn;
    logic       req0, req1, we0, we1;
    logic [8:0] addr0, addr1;
    logic [7:0] wdata0, wdata1, rdata;
    logic       gnt0, gnt1, done0, done1, err;

    apb_req_arbiter_if bus();

`ifdef APB_ARB_TIMEOUT_EN
    apb_req_arbiter #(.TIMEOUT(4)) dut (
`else
    apb_req_arbiter dut (
`endif
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err), .bus(bus)
    );

    typedef struct packed {
        logic       we;
        logic [8:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef struct {
        logic       who;
        cmd_t       cmd;
        int         waits;
        logic [7:0] prdata;
        logic [1:0] e_sel;
        logic [7:0] e_paddr;
        logic [7:0] e_pwdata;
        logic [7:0] e_rdata;
        int         e_done;
    } vec_t;

    int total = 0;
    int bad = 0;
    int overlap = 0;

    int         obs_who[2], obs_dwho[2], gnt_cyc[2], done_cyc[2];
    logic       obs_psel1[2], obs_psel2[2], obs_pwrite[2], obs_err[2];
    logic [7:0] obs_paddr[2], obs_pwdata[2], obs_rdata[2];
    int         n_gnt, n_done, hold_bad, dual_done;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) if (bus.PSEL1 && bus.PSEL2) overlap++;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        PRESETn = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        bus.PREADY = 1'b0; bus.PRDATA = '0;
        repeat (2) @(negedge PCLK);
        checkOutput("reset_ctrl", 32'({gnt0, gnt1, done0, done1, err, bus.PSEL1, bus.PSEL2,
                                       bus.PENABLE, bus.PWRITE}), 32'd0);
        checkOutput("reset_data", 32'({rdata, bus.PADDR, bus.PWDATA}), 32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);
    endtask

    // Raises the chosen requests and plays the slave; transfer k (in grant order) sees
    // its given number of wait cycles and read data.
    task automatic applyStimulus(input logic r0, input logic r1, input cmd_t c0, input cmd_t c1,
                                 input int wA, input int wB, input logic [7:0] dA, input logic [7:0] dB);
        int         need, acc, k, lim;
        logic       rdy;
        logic [7:0] d;
        need = int'(r0) + int'(r1);
        n_gnt = 0; n_done = 0; hold_bad = 0; dual_done = 0; acc = 0;
        for (int i = 0; i < 2; i++) begin
            obs_who[i] = -1; obs_dwho[i] = -1; gnt_cyc[i] = -1; done_cyc[i] = -1;
        end
        req0 = r0; we0 = c0.we; addr0 = c0.addr; wdata0 = c0.wdata;
        req1 = r1; we1 = c1.we; addr1 = c1.addr; wdata1 = c1.wdata;
        for (int n = 1; n <= 60 && n_done < need; n++) begin
            @(negedge PCLK);
            if ((gnt0 || gnt1) && n_gnt < 2) begin
                obs_who[n_gnt]    = gnt1 ? 1 : 0;
                gnt_cyc[n_gnt]    = n;
                obs_psel1[n_gnt]  = bus.PSEL1;
                obs_psel2[n_gnt]  = bus.PSEL2;
                obs_paddr[n_gnt]  = bus.PADDR;
                obs_pwrite[n_gnt] = bus.PWRITE;
                obs_pwdata[n_gnt] = bus.PWDATA;
                if (gnt0) req0 = 1'b0;
                if (gnt1) req1 = 1'b0;
                n_gnt++;
                acc = 0;
            end
            if (done0 || done1) begin
                if (done0 && done1) dual_done++;
                if (n_done < 2) begin
                    obs_dwho[n_done]  = done1 ? 1 : 0;
                    done_cyc[n_done]  = n;
                    obs_rdata[n_done] = rdata;
                    obs_err[n_done]   = err;
                end
                n_done++;
            end
            k = (n_gnt > 0) ? n_gnt - 1 : 0;
            if (bus.PENABLE) begin
                acc++;
                if (bus.PSEL1 !== obs_psel1[k] || bus.PSEL2 !== obs_psel2[k] ||
                    bus.PADDR !== obs_paddr[k] || bus.PWRITE !== obs_pwrite[k] ||
                    bus.PWDATA !== obs_pwdata[k]) hold_bad++;
            end
            lim = (k == 0) ? wA : wB;
            d   = (k == 0) ? dA : dB;
            rdy = bus.PENABLE && (acc > lim);
            bus.PREADY = rdy;
            bus.PRDATA = rdy ? d : ~d;
        end
        bus.PREADY = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge PCLK);
        checkOutput("idle_quiet", 32'({gnt0, gnt1, done0, done1, bus.PSEL1, bus.PSEL2, bus.PENABLE}), 32'd0);
        checkOutput("grant_count", 32'(n_gnt), 32'(need));
        checkOutput("done_count", 32'(n_done), 32'(need));
        checkOutput("access_hold", 32'(hold_bad), 32'd0);
        checkOutput("dual_done", 32'(dual_done), 32'd0);
    endtask

    task automatic checkTransfer(input int k, input int who, input logic we, input logic [1:0] e_sel,
                                 input logic [7:0] e_paddr, input int e_gnt, input int e_done,
                                 input logic [7:0] e_pwdata, input logic [7:0] e_rdata);
        checkOutput("gnt_who", 32'(obs_who[k]), 32'(who));
        checkOutput("gnt_cycle", 32'(gnt_cyc[k]), 32'(e_gnt));
        checkOutput("psel", 32'({obs_psel1[k], obs_psel2[k]}), 32'(e_sel));
        checkOutput("paddr", 32'(obs_paddr[k]), 32'(e_paddr));
        checkOutput("pwrite", 32'(obs_pwrite[k]), 32'(we));
        checkOutput("pwdata", 32'(obs_pwdata[k]), 32'(e_pwdata));
        checkOutput("done_who", 32'(obs_dwho[k]), 32'(who));
        checkOutput("done_cycle", 32'(done_cyc[k]), 32'(e_done));
        checkOutput("rdata", 32'(obs_rdata[k]), 32'(e_rdata));
        checkOutput("err", 32'(obs_err[k]), 32'd0);
    endtask

    initial begin
        vec_t       vecs[7];
        cmd_t       c, c0, c1;
        int         order[4], gcyc[4];
        int         ng, spur, pat, need, first, who, eg, ed, prev_done, wA, wB;
        logic       last_m;
        logic [7:0] rd_m, pwd_m, dA, dB;
`ifdef APB_ARB_TIMEOUT_EN
        int         dc;
        logic       errv;
        logic [7:0] rdv;
        logic [2:0] busv;
`endif

        //            who    {we, addr, wdata}           waits prdata  sel    paddr  pwdata rdata  done
        vecs[0] = '{1'b0, '{1'b1, 9'd5,   8'd55},  0, 8'h00,  2'b10, 8'd5,  8'd55, 8'd0,   3};
        vecs[1] = '{1'b1, '{1'b0, 9'd260, 8'h00},  2, 8'd123, 2'b01, 8'd4,  8'd55, 8'd123, 5};
        vecs[2] = '{1'b0, '{1'b1, 9'h1FF, 8'hA5},  1, 8'h00,  2'b01, 8'hFF, 8'hA5, 8'd123, 4};
        vecs[3] = '{1'b1, '{1'b0, 9'h0FF, 8'h00},  0, 8'h3C,  2'b10, 8'hFF, 8'hA5, 8'h3C,  3};
        vecs[4] = '{1'b0, '{1'b0, 9'h100, 8'h00},  3, 8'h00,  2'b01, 8'h00, 8'hA5, 8'h00,  6};
        vecs[5] = '{1'b1, '{1'b1, 9'h000, 8'hFF},  0, 8'h00,  2'b10, 8'h00, 8'hFF, 8'h00,  3};
        vecs[6] = '{1'b0, '{1'b0, 9'h080, 8'h00},  0, 8'h81,  2'b10, 8'h80, 8'hFF, 8'h81,  3};

        doReset();

        for (int v = 0; v < 7; v++) begin
            applyStimulus(~vecs[v].who, vecs[v].who, vecs[v].cmd, vecs[v].cmd,
                          vecs[v].waits, 0, vecs[v].prdata, 8'h00);
            checkTransfer(0, int'(vecs[v].who), vecs[v].cmd.we, vecs[v].e_sel, vecs[v].e_paddr,
                          1, vecs[v].e_done, vecs[v].e_pwdata, vecs[v].e_rdata);
        end

        // Reset asserted in the ACCESS phase of a write: bus drops at once, no done follows.
        req0 = 1'b1; we0 = 1'b1; addr0 = 9'h010; wdata0 = 8'h77; bus.PREADY = 1'b0;
        @(negedge PCLK);
        req0 = 1'b0;
        @(negedge PCLK);
        checkOutput("pre_reset_access", 32'(bus.PENABLE), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        checkOutput("async_reset_ctrl", 32'({gnt0, gnt1, done0, done1, err, bus.PSEL1, bus.PSEL2,
                                             bus.PENABLE, bus.PWRITE}), 32'd0);
        checkOutput("async_reset_data", 32'({rdata, bus.PADDR, bus.PWDATA}), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        bus.PREADY = 1'b1;
        spur = 0;
        repeat (4) begin
            @(negedge PCLK);
            if (done0 || done1 || gnt0 || gnt1) spur++;
        end
        bus.PREADY = 1'b0;
        checkOutput("no_done_after_reset", 32'(spur), 32'd0);
        c = '{1'b0, 9'h1C3, 8'h00};
        applyStimulus(1'b1, 1'b0, c, c, 1, 0, 8'h5A, 8'h00);
        checkTransfer(0, 0, 1'b0, 2'b01, 8'hC3, 1, 4, 8'h00, 8'h5A);

`ifdef APB_ARB_TIMEOUT_EN
        // Slave never ready: four ACCESS cycles, then an error completion.
        req1 = 1'b1; we1 = 1'b0; addr1 = 9'h1AA; wdata1 = 8'h00;
        bus.PREADY = 1'b0; bus.PRDATA = 8'hEE;
        dc = -1; errv = 1'b0; rdv = 8'hFF; busv = 3'b111;
        for (int n = 1; n <= 30 && dc < 0; n++) begin
            @(negedge PCLK);
            if (gnt1) req1 = 1'b0;
            if (done1) begin
                dc = n; errv = err; rdv = rdata;
                busv = {bus.PSEL1, bus.PSEL2, bus.PENABLE};
            end
        end
        req1 = 1'b0;
        checkOutput("timeout_done_cycle", 32'(dc), 32'd6);
        checkOutput("timeout_err", 32'(errv), 32'd1);
        checkOutput("timeout_rdata", 32'(rdv), 32'd0);
        checkOutput("timeout_bus_released", 32'(busv), 32'd0);
        @(negedge PCLK);
        checkOutput("timeout_err_width", 32'({err, done1}), 32'd0);
        c = '{1'b1, 9'h033, 8'h99};
        applyStimulus(1'b1, 1'b0, c, c, 0, 0, 8'h00, 8'h00);
        checkTransfer(0, 0, 1'b1, 2'b10, 8'h33, 1, 3, 8'h99, 8'h00);
`endif

        // Both requests held from reset: strict alternation, one grant every 3 cycles.
        doReset();
        for (int i = 0; i < 4; i++) begin order[i] = -1; gcyc[i] = -1; end
        req0 = 1'b1; we0 = 1'b1; addr0 = 9'h011; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b0; addr1 = 9'h122; wdata1 = 8'h00;
        ng = 0;
        for (int n = 1; n <= 40 && ng < 4; n++) begin
            @(negedge PCLK);
            if (gnt0 || gnt1) begin
                order[ng] = gnt1 ? 1 : 0;
                gcyc[ng]  = n;
                ng++;
                if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
            bus.PREADY = bus.PENABLE; bus.PRDATA = 8'h44;
        end
        repeat (4) begin
            @(negedge PCLK);
            bus.PREADY = bus.PENABLE;
        end
        bus.PREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("rr_order", 32'(order[i]), 32'(i % 2));
            checkOutput("rr_gnt_cycle", 32'(gcyc[i]), 32'(1 + 3 * i));
        end

        // Random single/dual requests against a transaction-level model.
        doReset();
        last_m = 1'b1; rd_m = 8'h00; pwd_m = 8'h00;
        for (int it = 0; it < 40; it++) begin
            pat = int'($urandom_range(1, 3));
            c0  = cmd_t'(18'($urandom));
            c1  = cmd_t'(18'($urandom));
            wA  = int'($urandom_range(0, 3));
            wB  = int'($urandom_range(0, 3));
            dA  = 8'($urandom);
            dB  = 8'($urandom);
            applyStimulus(pat[0], pat[1], c0, c1, wA, wB, dA, dB);
            need  = (pat == 3) ? 2 : 1;
            first = (pat == 3) ? (last_m ? 0 : 1) : ((pat == 2) ? 1 : 0);
            prev_done = 0;
            for (int k = 0; k < need; k++) begin
                who = (k == 0) ? first : 1 - first;
                c   = (who == 1) ? c1 : c0;
                eg  = (k == 0) ? 1 : prev_done + 1;
                ed  = eg + 2 + ((k == 0) ? wA : wB);
                if (c.we) pwd_m = c.wdata;
                else      rd_m  = (k == 0) ? dA : dB;
                checkTransfer(k, who, c.we, {~c.addr[8], c.addr[8]}, c.addr[7:0], eg, ed, pwd_m, rd_m);
                prev_done = ed;
                last_m    = (who == 1);
            end
        end

        checkOutput("psel_exclusive", 32'(overlap), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
